// File: rtl/pipe_ctrl_seq.sv
// EX-stage control sequencer for the three-stage MIPS pipeline: ID decode into a
// registered EX control word, branch/jump resolution, flush sequencing and HI/LO interlock.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue, no redirect in progress, HI/LO idle
// REDIRECT  | taken branch/jump being drained; flush held, EX fed bubbles
// MULT_WAIT | multiply in flight; HI/LO consumers and multiplies held in ID
module pipe_ctrl_seq #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MULT_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] op_code,
  input  logic [5:0] function_code,
  input  logic [4:0] shamt,
  input  logic       alu_zero,
  input  logic       alu_lo,
  output logic [3:0] alu_op,
  output logic [4:0] alu_shamt,
  output logic [1:0] rdrt,
  output logic [2:0] regsel,
  output logic       regwrite,
  output logic       memwrite_EX,
  output logic       enhilo,
  output logic [1:0] pcsrc_EX,
  output logic       stall_ID,
  output logic       flush,
  output logic       mult_busy,
  output logic       illegal_EX
);

  typedef enum logic [1:0] {RUN, REDIRECT, MULT_WAIT} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_JUMP, BR_JREG} br_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] alu_shamt;
    logic [1:0] rdrt;
    logic [2:0] regsel;
    logic       regwrite;
    logic       memwrite;
    logic       enhilo;
    logic       illegal;
    br_t        br;
  } ctrl_t;

  localparam ctrl_t      BUBBLE     = ctrl_t'('0);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [3:0] MULT_LOAD  = 4'(MULT_LATENCY - 1);

  state_t     state_q;
  ctrl_t      ex_q;
  ctrl_t      dec;
  logic       id_interlock;
  logic [1:0] flush_cnt_q;
  logic [3:0] mult_cnt_q;
  logic [3:0] mult_cnt_nxt;
  logic       redirect;
  logic       mult_hazard;
  state_t     settle_state;

  // ID decode; id_interlock marks instructions that touch HI/LO.
  always_comb begin
    dec          = BUBBLE;
    id_interlock = 1'b0;
    case (op_code)
      6'b000000: begin
        case (function_code)
          6'b100000, 6'b100001: begin dec.alu_op = 4'b0100; dec.regwrite = 1'b1; end
          6'b100010, 6'b100011: begin dec.alu_op = 4'b0101; dec.regwrite = 1'b1; end
          6'b100100: begin dec.alu_op = 4'b0000; dec.regwrite = 1'b1; end
          6'b100101: begin dec.alu_op = 4'b0001; dec.regwrite = 1'b1; end
          6'b100111: begin dec.alu_op = 4'b0010; dec.regwrite = 1'b1; end
          6'b100110: begin dec.alu_op = 4'b0011; dec.regwrite = 1'b1; end
          6'b101010: begin dec.alu_op = 4'b1100; dec.regwrite = 1'b1; end
          6'b101011: begin dec.alu_op = 4'b1111; dec.regwrite = 1'b1; end
          6'b000000: begin
            // SLL by zero is the canonical NOP and stays a bubble
            if (shamt != 5'd0) begin
              dec.alu_op    = 4'b1000;
              dec.alu_shamt = shamt;
              dec.regwrite  = 1'b1;
            end
          end
          6'b000010: begin dec.alu_op = 4'b1001; dec.alu_shamt = shamt; dec.regwrite = 1'b1; end
          6'b000011: begin dec.alu_op = 4'b1011; dec.alu_shamt = shamt; dec.regwrite = 1'b1; end
          6'b011000: begin dec.alu_op = 4'b0110; dec.enhilo = 1'b1; id_interlock = 1'b1; end
          6'b011001: begin dec.alu_op = 4'b0111; dec.enhilo = 1'b1; id_interlock = 1'b1; end
          6'b010000: begin dec.regsel = 3'd1; dec.regwrite = 1'b1; id_interlock = 1'b1; end
          6'b010010: begin dec.regsel = 3'd2; dec.regwrite = 1'b1; id_interlock = 1'b1; end
          6'b001000: dec.br = BR_JREG;
          default:   dec.illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin dec.alu_op = 4'b1000; dec.rdrt = 2'd1; dec.regwrite = 1'b1; end
      6'b001100: begin dec.alu_op = 4'b1100; dec.rdrt = 2'd1; dec.regwrite = 1'b1; end
      6'b001101: begin dec.alu_op = 4'b1101; dec.rdrt = 2'd1; dec.regwrite = 1'b1; end
      6'b001110: begin dec.alu_op = 4'b1110; dec.rdrt = 2'd1; dec.regwrite = 1'b1; end
      6'b001010: begin dec.alu_op = 4'b1010; dec.rdrt = 2'd1; dec.regwrite = 1'b1; end
      6'b100011: begin
        dec.alu_op   = 4'b0001;
        dec.rdrt     = 2'd1;
        dec.regsel   = 3'd3;
        dec.regwrite = 1'b1;
      end
      6'b101011: begin dec.alu_op = 4'b1011; dec.memwrite = 1'b1; end
      6'b001111: begin
        dec.alu_op    = 4'b1111;
        dec.alu_shamt = 5'd16;
        dec.rdrt      = 2'd1;
        dec.regwrite  = 1'b1;
      end
      6'b000100: begin dec.alu_op = 4'b0011; dec.br = BR_BEQ;  end
      6'b000101: begin dec.alu_op = 4'b1110; dec.br = BR_BNE;  end
      6'b000001: begin dec.alu_op = 4'b1001; dec.br = BR_BGEZ; end
      6'b000010: dec.br = BR_JUMP;
      6'b000011: begin
        dec.br       = BR_JUMP;
        dec.rdrt     = 2'd3;
        dec.regsel   = 3'd4;
        dec.regwrite = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    pcsrc_EX = 2'd0;
    case (ex_q.br)
      BR_BEQ:  if (alu_zero)  pcsrc_EX = 2'd1;
      BR_BNE:  if (!alu_zero) pcsrc_EX = 2'd1;
      BR_BGEZ: if (alu_lo)    pcsrc_EX = 2'd1;
      BR_JUMP: pcsrc_EX = 2'd2;
      BR_JREG: pcsrc_EX = 2'd3;
      default: pcsrc_EX = 2'd0;
    endcase
  end

  assign redirect = (pcsrc_EX != 2'd0);
  assign flush    = ~reset & (redirect | (state_q == REDIRECT));

  // A consumer must leave ID no earlier than the last busy cycle, so the hold
  // starts while the multiply itself is in EX and ends one cycle before busy drops.
  assign mult_hazard = (ex_q.enhilo && (MULT_LOAD != 4'd0)) || (mult_cnt_q > 4'd1);
  assign stall_ID    = ~reset & ~flush & instr_valid & id_interlock & mult_hazard;
  assign mult_busy   = (mult_cnt_q != 4'd0);

  always_comb begin
    mult_cnt_nxt = 4'd0;
    if (ex_q.enhilo)
      mult_cnt_nxt = MULT_LOAD;
    else if (mult_cnt_q != 4'd0)
      mult_cnt_nxt = mult_cnt_q - 4'd1;
  end

  assign settle_state = (mult_cnt_nxt != 4'd0) ? MULT_WAIT : RUN;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ex_q        <= BUBBLE;
      flush_cnt_q <= 2'd0;
      mult_cnt_q  <= 4'd0;
    end else begin
      ex_q       <= (instr_valid && !flush && !stall_ID) ? dec : BUBBLE;
      mult_cnt_q <= mult_cnt_nxt;
      case (state_q)
        REDIRECT: begin
          flush_cnt_q <= flush_cnt_q - 2'd1;
          if (flush_cnt_q <= 2'd1)
            state_q <= settle_state;
        end
        RUN, MULT_WAIT: begin
          if (redirect) begin
            flush_cnt_q <= FLUSH_LOAD;
            state_q     <= (FLUSH_LOAD != 2'd0) ? REDIRECT : settle_state;
          end else begin
            state_q <= settle_state;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign alu_op      = ex_q.alu_op;
  assign alu_shamt   = ex_q.alu_shamt;
  assign rdrt        = ex_q.rdrt;
  assign regsel      = ex_q.regsel;
  assign regwrite    = ex_q.regwrite;
  assign memwrite_EX = ex_q.memwrite;
  assign enhilo      = ex_q.enhilo;
  assign illegal_EX  = ex_q.illegal;

endmodule
